// File: rtl/l0_cache_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// l0_cache_write_ctrl_if
// Bundles the store, fill, flush and cache-RAM write signals of the L0 cache
// write sequencer so they can be passed around as one port.
//
// Port summary (direction as seen by the sequencer, i.e. the slave modport):
//   i_store_valid/addr/data/byte_en : store commit from the MEM stage
//   i_fill_valid/addr/data, o_fill_ready : fill word handshake from memory
//   i_flush_req                     : invalidate-all request pulse
//   o_busy, o_flush_done            : sweep status
//   o_wr_en/index/tag/data/valid_bits : registered cache RAM write command
//
// master : the environment (pipeline + memory) driving requests
// slave  : the write sequencer itself
// ---------------------------------------------------------------------------
interface l0_cache_write_ctrl_if #(
    parameter int XLEN                = 32,
    parameter int CacheTagWidth       = 7,
    parameter int MEM_BYTE_ADDR_WIDTH = 16
);
    localparam int IndexWidth = MEM_BYTE_ADDR_WIDTH - 2 - CacheTagWidth;

    logic                     i_store_valid;
    logic [XLEN-1:0]          i_store_addr;
    logic [XLEN-1:0]          i_store_data;
    logic [XLEN/8-1:0]        i_store_byte_en;

    logic                     i_fill_valid;
    logic                     o_fill_ready;
    logic [XLEN-1:0]          i_fill_addr;
    logic [XLEN-1:0]          i_fill_data;

    logic                     i_flush_req;
    logic                     o_busy;
    logic                     o_flush_done;

    logic                     o_wr_en;
    logic [IndexWidth-1:0]    o_wr_index;
    logic [CacheTagWidth-1:0] o_wr_tag;
    logic [XLEN-1:0]          o_wr_data;
    logic [XLEN/8-1:0]        o_wr_valid_bits;

    modport master (
        output i_store_valid, i_store_addr, i_store_data, i_store_byte_en,
        output i_fill_valid, i_fill_addr, i_fill_data,
        output i_flush_req,
        input  o_fill_ready, o_busy, o_flush_done,
        input  o_wr_en, o_wr_index, o_wr_tag, o_wr_data, o_wr_valid_bits
    );

    modport slave (
        input  i_store_valid, i_store_addr, i_store_data, i_store_byte_en,
        input  i_fill_valid, i_fill_addr, i_fill_data,
        input  i_flush_req,
        output o_fill_ready, o_busy, o_flush_done,
        output o_wr_en, o_wr_index, o_wr_tag, o_wr_data, o_wr_valid_bits
    );
endinterface

// File: rtl/l0_cache_write_ctrl.sv
// ---------------------------------------------------------------------------
// l0_cache_write_ctrl
// Sequencer for the single write port of the L0 data cache. It arbitrates
// between write-through store updates and memory line fills, and runs an
// index sweep that invalidates every entry after reset and on flush.
// Every output is a register, so a request seen in one cycle shows up on the
// write port in the next.
//
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (restarts the invalidate sweep)
//   bus    : l0_cache_write_ctrl_if slave modport carrying store, fill,
//            flush, status and cache RAM write signals
// ---------------------------------------------------------------------------
module l0_cache_write_ctrl #(
    parameter int              XLEN                = 32,
    parameter int              CacheTagWidth       = 7,
    parameter int              MEM_BYTE_ADDR_WIDTH = 16,
    parameter logic [XLEN-1:0] MMIO_ADDR           = 32'h4000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    l0_cache_write_ctrl_if.slave  bus
);
    localparam int IndexWidth = MEM_BYTE_ADDR_WIDTH - 2 - CacheTagWidth;
    localparam int Depth      = 1 << IndexWidth;
    localparam int ByteLanes  = XLEN / 8;

    // The sweep counter has one extra bit so that the value Depth marks the
    // closing cycle, in which the done pulse is produced and busy drops.
    localparam logic [IndexWidth:0] SweepEnd = (IndexWidth + 1)'(Depth);
    localparam logic [IndexWidth:0] CntOne   = (IndexWidth + 1)'(1);

    typedef enum logic {
        SWEEP,
        IDLE
    } state_e;

    state_e                   state_q;
    logic [IndexWidth:0]      sweepCnt_q;

    logic                     bufValid_q;
    logic [IndexWidth-1:0]    bufIndex_q;
    logic [CacheTagWidth-1:0] bufTag_q;
    logic [XLEN-1:0]          bufData_q;

    logic                     wrEn_q;
    logic [IndexWidth-1:0]    wrIndex_q;
    logic [CacheTagWidth-1:0] wrTag_q;
    logic [XLEN-1:0]          wrData_q;
    logic [ByteLanes-1:0]     wrValidBits_q;
    logic                     busy_q;
    logic                     flushDone_q;
    logic                     fillReady_q;

    logic                     storeWrite;
    logic                     fillTake;
    logic [IndexWidth-1:0]    storeIndex;
    logic [CacheTagWidth-1:0] storeTag;
    logic [IndexWidth-1:0]    fillIndex;
    logic [CacheTagWidth-1:0] fillTag;

    // Address decode for both request sources. A store only writes when it
    // is cacheable and enables at least one byte. A fill is taken only when
    // the handshake completes and it is cacheable; MMIO fills still complete
    // the handshake but are simply thrown away.
    assign storeIndex = bus.i_store_addr[IndexWidth+1:2];
    assign storeTag   = bus.i_store_addr[MEM_BYTE_ADDR_WIDTH-1:IndexWidth+2];
    assign fillIndex  = bus.i_fill_addr[IndexWidth+1:2];
    assign fillTag    = bus.i_fill_addr[MEM_BYTE_ADDR_WIDTH-1:IndexWidth+2];
    assign storeWrite = bus.i_store_valid && (bus.i_store_addr < MMIO_ADDR)
                        && (|bus.i_store_byte_en);
    assign fillTake   = bus.i_fill_valid && fillReady_q
                        && (bus.i_fill_addr < MMIO_ADDR);

    // Main sequencer. A flush request wins over everything and restarts the
    // sweep; the flush cycle itself already issues the write for entry 0 so
    // that entries 0..Depth-1 land in the Depth cycles after the request.
    // Coming out of reset the counter sits at 0 and the first sweep cycle
    // issues entry 0 instead. In IDLE the order is store, buffered fill,
    // then a freshly accepted fill. A fill that loses to a store is parked
    // in the one-entry buffer, and fill_ready is dropped while it is full.
    // A later store to the parked fill's index kills it, since the fill
    // would otherwise overwrite newer store data with stale memory data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= SWEEP;
            sweepCnt_q    <= '0;
            bufValid_q    <= 1'b0;
            bufIndex_q    <= '0;
            bufTag_q      <= '0;
            bufData_q     <= '0;
            wrEn_q        <= 1'b0;
            wrIndex_q     <= '0;
            wrTag_q       <= '0;
            wrData_q      <= '0;
            wrValidBits_q <= '0;
            busy_q        <= 1'b1;
            flushDone_q   <= 1'b0;
            fillReady_q   <= 1'b0;
        end else begin
            wrEn_q      <= 1'b0;
            flushDone_q <= 1'b0;
            if (bus.i_flush_req) begin
                state_q       <= SWEEP;
                sweepCnt_q    <= CntOne;
                bufValid_q    <= 1'b0;
                wrEn_q        <= 1'b1;
                wrIndex_q     <= '0;
                wrTag_q       <= '0;
                wrData_q      <= '0;
                wrValidBits_q <= '0;
                busy_q        <= 1'b1;
                fillReady_q   <= 1'b0;
            end else if (state_q == SWEEP) begin
                if (sweepCnt_q == SweepEnd) begin
                    state_q     <= IDLE;
                    sweepCnt_q  <= '0;
                    busy_q      <= 1'b0;
                    flushDone_q <= 1'b1;
                    fillReady_q <= 1'b1;
                end else begin
                    wrEn_q        <= 1'b1;
                    wrIndex_q     <= sweepCnt_q[IndexWidth-1:0];
                    wrTag_q       <= '0;
                    wrData_q      <= '0;
                    wrValidBits_q <= '0;
                    sweepCnt_q    <= sweepCnt_q + CntOne;
                end
            end else if (storeWrite) begin
                wrEn_q        <= 1'b1;
                wrIndex_q     <= storeIndex;
                wrTag_q       <= storeTag;
                wrData_q      <= bus.i_store_data;
                wrValidBits_q <= bus.i_store_byte_en;
                if (fillTake) begin
                    bufValid_q  <= 1'b1;
                    bufIndex_q  <= fillIndex;
                    bufTag_q    <= fillTag;
                    bufData_q   <= bus.i_fill_data;
                    fillReady_q <= 1'b0;
                end else if (bufValid_q && (bufIndex_q == storeIndex)) begin
                    bufValid_q  <= 1'b0;
                    fillReady_q <= 1'b1;
                end else begin
                    fillReady_q <= !bufValid_q;
                end
            end else if (bufValid_q) begin
                wrEn_q        <= 1'b1;
                wrIndex_q     <= bufIndex_q;
                wrTag_q       <= bufTag_q;
                wrData_q      <= bufData_q;
                wrValidBits_q <= '1;
                bufValid_q    <= 1'b0;
                fillReady_q   <= 1'b1;
            end else if (fillTake) begin
                wrEn_q        <= 1'b1;
                wrIndex_q     <= fillIndex;
                wrTag_q       <= fillTag;
                wrData_q      <= bus.i_fill_data;
                wrValidBits_q <= '1;
            end
        end
    end

    // Everything leaving the block comes straight from a register.
    assign bus.o_wr_en          = wrEn_q;
    assign bus.o_wr_index       = wrIndex_q;
    assign bus.o_wr_tag         = wrTag_q;
    assign bus.o_wr_data        = wrData_q;
    assign bus.o_wr_valid_bits  = wrValidBits_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_flush_done     = flushDone_q;
    assign bus.o_fill_ready     = fillReady_q;
endmodule

// File: tb/tb_l0_cache_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l0_cache_write_ctrl
// Drives directed and random store/fill/flush/reset traffic into the L0 cache
// write sequencer. A cycle-numbered reference model turns each cycle's
// requests into expected cache writes and expected status flags, queued for
// a separate monitor that compares them against the outputs at negedge.
// ---------------------------------------------------------------------------
module tb_l0_cache_write_ctrl;
    localparam int          Depth = 128;
    localparam logic [31:0] Mmio  = 32'h4000_0000;

    typedef struct {
        int         cyc;
        logic [6:0] idx;
        logic [6:0] tag;
        logic [31:0] data;
        logic [3:0] vb;
    } wr_t;

    typedef struct {
        int cyc;
        bit busy;
        bit done;
        bit ready;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    wr_t  wrQ[$];
    st_t  stQ[$];

    // Reference model state: last cycle of the current sweep (busy while the
    // cycle number is at or below it) and the one-entry parked fill.
    bit         live = 1'b0;
    int         sweepEnd = -1000;
    bit         bufV = 1'b0;
    logic [6:0] bufIdx;
    logic [6:0] bufTag;
    logic [31:0] bufData;

    l0_cache_write_ctrl_if #(.XLEN(32), .CacheTagWidth(7), .MEM_BYTE_ADDR_WIDTH(16)) bus ();

    l0_cache_write_ctrl #(
        .XLEN(32), .CacheTagWidth(7), .MEM_BYTE_ADDR_WIDTH(16), .MMIO_ADDR(32'h4000_0000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Cycle number; stimulus and monitor both read it after the posedge update.
    always @(posedge clk) cyc <= cyc + 1;

    // Entry index is the word number modulo the number of entries; tag is
    // the 512-byte block number modulo 128 (64 KiB cacheable space).
    function automatic logic [6:0] idxOf(input logic [31:0] a);
        return 7'((a / 4) % Depth);
    endfunction

    function automatic logic [6:0] tagOf(input logic [31:0] a);
        return 7'((a / 512) % 128);
    endfunction

    // Queue the invalidate writes of a fresh sweep, dropping anything that
    // was expected from cycle truncFrom onwards.
    task automatic scheduleSweep(input int truncFrom, input int first);
        while (wrQ.size() > 0 && wrQ[$].cyc >= truncFrom) void'(wrQ.pop_back());
        for (int i = 0; i < Depth; i++) wrQ.push_back('{first + i, 7'(i), 7'd0, 32'd0, 4'd0});
        sweepEnd = first + Depth - 1;
        bufV = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model.
    task automatic applyStimulus(input bit r, input bit fl,
                                 input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic [3:0] sbe,
                                 input bit fv, input logic [31:0] fa, input logic [31:0] fd);
        int  c;
        bit  ready;
        bit  storeW;
        bit  fillAcc;
        @(posedge clk);
        #1;
        rst                 = r;
        bus.i_flush_req     = fl;
        bus.i_store_valid   = sv;
        bus.i_store_addr    = sa;
        bus.i_store_data    = sd;
        bus.i_store_byte_en = sbe;
        bus.i_fill_valid    = fv;
        bus.i_fill_addr     = fa;
        bus.i_fill_data     = fd;
        c = cyc;
        ready = (c > sweepEnd) && !bufV;
        if (live) stQ.push_back('{c, (c <= sweepEnd), (c == sweepEnd + 1), ready});
        if (r) begin
            scheduleSweep(c + 1, c + 2);
            live = 1'b1;
        end else if (live) begin
            if (fl) begin
                scheduleSweep(c + 1, c + 1);
            end else if (c > sweepEnd) begin
                storeW  = sv && (sa < Mmio) && (sbe != 4'd0);
                fillAcc = fv && ready;
                if (storeW) begin
                    wrQ.push_back('{c + 1, idxOf(sa), tagOf(sa), sd, sbe});
                    if (bufV && bufIdx == idxOf(sa)) bufV = 1'b0;
                    if (fillAcc && fa < Mmio) begin
                        bufV = 1'b1;
                        bufIdx = idxOf(fa);
                        bufTag = tagOf(fa);
                        bufData = fd;
                    end
                end else if (bufV) begin
                    wrQ.push_back('{c + 1, bufIdx, bufTag, bufData, 4'hF});
                    bufV = 1'b0;
                end else if (fillAcc && fa < Mmio) begin
                    wrQ.push_back('{c + 1, idxOf(fa), tagOf(fa), fd, 4'hF});
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare status every cycle, and every write (or missing
    // write) against the head of the expected write queue.
    always @(negedge clk) begin
        st_t s;
        wr_t w;
        while (stQ.size() > 0 && stQ[0].cyc < cyc) void'(stQ.pop_front());
        if (stQ.size() > 0 && stQ[0].cyc == cyc) begin
            s = stQ.pop_front();
            checkOutput("status busy/done/ready", {61'd0, bus.o_busy, bus.o_flush_done, bus.o_fill_ready},
                        {61'd0, s.busy, s.done, s.ready});
        end
        while (wrQ.size() > 0 && wrQ[0].cyc < cyc) void'(wrQ.pop_front());
        if (wrQ.size() > 0 && wrQ[0].cyc == cyc) begin
            w = wrQ.pop_front();
            checkOutput("wr_en expected", {63'd0, bus.o_wr_en}, 64'd1);
            if (bus.o_wr_en === 1'b1)
                checkOutput("write idx/tag/data/vb",
                            {14'd0, bus.o_wr_index, bus.o_wr_tag, bus.o_wr_data, bus.o_wr_valid_bits},
                            {14'd0, w.idx, w.tag, w.data, w.vb});
        end else if (live && bus.o_wr_en !== 1'b0) begin
            checkOutput("wr_en unexpected", {63'd0, bus.o_wr_en}, 64'd0);
        end
    end

    initial begin
        logic [31:0] sa;
        logic [31:0] fa;
        bus.i_flush_req = 0; bus.i_store_valid = 0; bus.i_store_addr = 0; bus.i_store_data = 0;
        bus.i_store_byte_en = 0; bus.i_fill_valid = 0; bus.i_fill_addr = 0; bus.i_fill_data = 0;

        // Reset and the post-reset sweep
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(135);

        // Basic store, MMIO store, zero-enable store
        applyStimulus(0, 0, 1, 32'h0000_1234, 32'hAABB_CCDD, 4'b0011, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h4000_0000, 32'h1234_5678, 4'hF, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h0000_0010, 32'h5555_5555, 4'h0, 0, 0, 0);
        idle(2);

        // Store and fill together: fill parked, written one cycle later
        applyStimulus(0, 0, 1, 32'h0000_0100, 32'h0102_0304, 4'hF, 1, 32'h0000_0200, 32'h1111_2222);
        idle(3);

        // Parked fill killed by a store to the same index
        applyStimulus(0, 0, 1, 32'h0000_0300, 32'h3333_3333, 4'hC, 1, 32'h0000_0100, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 1, 32'h0000_0100, 32'h4444_4444, 4'hF, 0, 0, 0);
        idle(3);

        // Parked fill delayed by a store to another index
        applyStimulus(0, 0, 1, 32'h0000_0700, 32'h7777_0000, 4'h1, 1, 32'h0000_0904, 32'h9999_0000);
        applyStimulus(0, 0, 1, 32'h0000_0A00, 32'hAAAA_0000, 4'h2, 0, 0, 0);
        idle(3);

        // MMIO fill discarded, then a plain fill
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h4000_0010, 32'hFFFF_0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_FFFC, 32'h0BAD_F00D);
        idle(2);

        // Flush, restart mid-sweep with a concurrent store
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(60);
        applyStimulus(0, 1, 1, 32'h0000_0040, 32'h6060_6060, 4'hF, 0, 0, 0);
        idle(135);

        // Reset while a fill is parked
        applyStimulus(0, 0, 1, 32'h0000_0500, 32'h5050_5050, 4'hF, 1, 32'h0000_0600, 32'h6666_6666);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(135);

        // Random traffic over a handful of indices so collisions are common
        for (int i = 0; i < 3000; i++) begin
            sa = ($urandom_range(0, 7) == 0) ? (Mmio + ($urandom & 32'hFFFC)) :
                 ((32'($urandom_range(0, 127)) << 9) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)));
            fa = ($urandom_range(0, 7) == 0) ? (Mmio + 32'h100) :
                 ((32'($urandom_range(0, 127)) << 9) | (32'($urandom_range(0, 3)) << 2));
            applyStimulus($urandom_range(0, 599) == 0, $urandom_range(0, 249) == 0,
                          $urandom_range(0, 9) < 4, sa, $urandom, 4'($urandom),
                          $urandom_range(0, 1) == 1, fa, $urandom);
        end

        idle(140);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
